// File: rtl/uart_tx_engine_pkg.sv
// Shared types and constants for the UART transmit engine.
package uart_tx_engine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int unsigned BAUD_W_DEF = 18;
    localparam int unsigned DATA8      = 8;
    localparam int unsigned DATA7      = 7;

endpackage

// File: rtl/uart_tx_engine_bit_timer.sv
// Bit-time counter: emits a one-cycle btu pulse on the last clock of each bit.
module tx_bit_timer
    import uart_tx_engine_pkg::*;
#(
    parameter int unsigned BAUD_W = BAUD_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              run,
    input  logic [BAUD_W-1:0] baud_count,
    output logic              btu
);

    logic [BAUD_W-1:0] cnt_q;
    logic [BAUD_W-1:0] cnt_d;
    logic [BAUD_W-1:0] last;

    // baud_count of 0 or 1 both mean one clock per bit; >= keeps the count from wrapping.
    always_comb begin
        last  = (baud_count > BAUD_W'(1)) ? baud_count - 1'b1 : '0;
        btu   = run && (cnt_q >= last);
        cnt_d = (btu || !run) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, 7/8 data bits LSB first, optional parity, one stop bit.
module uart_tx_engine
    import uart_tx_engine_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BAUD_W = BAUD_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              load,
    input  logic [DATA_W-1:0] out_port,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic [BAUD_W-1:0] baud_count,
    output logic              TxRdy,
    output logic              Tx
);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [3:0]        bitcnt_q, bitcnt_d;
    logic [3:0]        nbits_q, nbits_d;
    logic              pen_q, pen_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              rdy_q, rdy_d;
    logic              btu;
    logic [DATA_W-1:0] data_mask;

    tx_bit_timer #(
        .BAUD_W(BAUD_W)
    ) u_timer (
        .Clk       (Clk),
        .Rst       (Rst),
        .run       (state_q != IDLE),
        .baud_count(baud_count),
        .btu       (btu)
    );

    assign data_mask = eight ? '1 : {1'b0, {(DATA_W-1){1'b1}}};

    // Tx is computed for the state being entered so the line changes on the same edge.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        nbits_d  = nbits_q;
        pen_d    = pen_q;
        par_d    = par_q;
        tx_d     = tx_q;
        rdy_d    = rdy_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d  = START;
                    shreg_d  = out_port & data_mask;
                    nbits_d  = eight ? 4'(DATA8) : 4'(DATA7);
                    pen_d    = pen;
                    par_d    = (^(out_port & data_mask)) ^ ohel;
                    bitcnt_d = '0;
                    tx_d     = 1'b0;
                    rdy_d    = 1'b0;
                end
            end
            START: begin
                if (btu) begin
                    state_d  = DATA;
                    tx_d     = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = 4'd1;
                end
            end
            DATA: begin
                if (btu) begin
                    if (bitcnt_q == nbits_q) begin
                        state_d = pen_q ? PARITY : STOP;
                        tx_d    = pen_q ? par_q : 1'b1;
                    end else begin
                        tx_d     = shreg_q[0];
                        shreg_d  = shreg_q >> 1;
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (btu) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (btu) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                rdy_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            nbits_q  <= '0;
            pen_q    <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            nbits_q  <= nbits_d;
            pen_q    <= pen_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            rdy_q    <= rdy_d;
        end
    end

    assign Tx    = tx_q;
    assign TxRdy = rdy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: frames predicted from byte/config by a bit-list model.
module tb_uart_tx_engine;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        load = 1'b0;
    logic [7:0]  out_port = '0;
    logic        eight = 1'b1;
    logic        pen = 1'b0;
    logic        ohel = 1'b0;
    logic [17:0] baud_count = 18'd4;
    logic        TxRdy;
    logic        Tx;

    int unsigned errors = 0;
    int unsigned checks = 0;

    uart_tx_engine #(.DATA_W(8), .BAUD_W(18)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .load      (load),
        .out_port  (out_port),
        .eight     (eight),
        .pen       (pen),
        .ohel      (ohel),
        .baud_count(baud_count),
        .TxRdy     (TxRdy),
        .Tx        (Tx)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Expected line levels, one entry per bit time, built from the framing rules.
    function automatic void build_frame(input logic [7:0] d, input logic e, input logic p,
                                        input logic o, output logic bits[$]);
        int unsigned ones;
        int unsigned nd;
        bits.delete();
        ones = 0;
        nd = e ? 8 : 7;
        bits.push_back(1'b0);
        for (int unsigned i = 0; i < nd; i++) begin
            bits.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (p) bits.push_back(o ? ((ones % 2) == 0) : ((ones % 2) == 1));
        bits.push_back(1'b1);
    endfunction

    // Sends one frame and checks every clock of it; busy_clk >= 0 pulses an ignored load there.
    task automatic send(input string tag, input logic [7:0] d, input logic e, input logic p,
                        input logic o, input int unsigned baud, input int busy_clk,
                        input logic [7:0] busy_d);
        logic bits[$];
        int unsigned b;
        int clk_idx;
        build_frame(d, e, p, o, bits);
        b = (baud < 2) ? 1 : baud;
        baud_count = 18'(baud);
        out_port = d; eight = e; pen = p; ohel = o; load = 1'b1;
        step();
        load = 1'b0;
        // Scramble the live config; the frame in flight must not notice.
        out_port = 8'($urandom); eight = 1'($urandom); pen = 1'($urandom); ohel = 1'($urandom);
        clk_idx = 0;
        foreach (bits[i]) begin
            for (int unsigned c = 0; c < b; c++) begin
                check($sformatf("%s bit%0d clk%0d Tx", tag, i, c), Tx, bits[i]);
                check($sformatf("%s bit%0d clk%0d TxRdy", tag, i, c), TxRdy, 1'b0);
                if (clk_idx == busy_clk) begin
                    out_port = busy_d; load = 1'b1;
                end else begin
                    load = 1'b0;
                end
                clk_idx++;
                step();
            end
        end
        load = 1'b0;
        check({tag, " end TxRdy"}, TxRdy, 1'b1);
        check({tag, " end Tx"}, Tx, 1'b1);
    endtask

    task automatic idle(input string tag, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            step();
            check({tag, " idle Tx"}, Tx, 1'b1);
            check({tag, " idle TxRdy"}, TxRdy, 1'b1);
        end
    endtask

    initial begin
        logic [7:0] rd;
        // Reset held with load asserted: nothing may start.
        Rst = 1'b1; load = 1'b1; out_port = 8'h00;
        step();
        check("rst0 Tx", Tx, 1'b1);
        check("rst0 TxRdy", TxRdy, 1'b1);
        step();
        check("rst1 Tx", Tx, 1'b1);
        check("rst1 TxRdy", TxRdy, 1'b1);
        Rst = 1'b0; load = 1'b0;
        idle("post_rst", 2);

        send("8N1_55", 8'h55, 1'b1, 1'b0, 1'b0, 4, -1, 8'h00);
        idle("gap1", 1);
        send("8E1_07", 8'h07, 1'b1, 1'b1, 1'b0, 3, -1, 8'h00);
        idle("gap2", 1);
        send("8O1_07", 8'h07, 1'b1, 1'b1, 1'b1, 3, -1, 8'h00);
        idle("gap3", 2);
        send("7N1_81", 8'h81, 1'b0, 1'b0, 1'b0, 2, -1, 8'h00);
        idle("gap4", 1);
        // Busy load ignored, then a load on the TxRdy-rise cycle chains straight on.
        send("busy_3C", 8'h3C, 1'b1, 1'b0, 1'b0, 3, 10, 8'hAA);
        send("b2b_0F", 8'h0F, 1'b1, 1'b0, 1'b0, 3, -1, 8'h00);
        idle("gap5", 1);
        send("baud1", 8'hC9, 1'b1, 1'b1, 1'b0, 1, -1, 8'h00);
        send("baud0", 8'h36, 1'b0, 1'b1, 1'b1, 0, -1, 8'h00);
        idle("gap6", 1);

        // Reset during data bit 3 (clocks 12..14 of a B=3 frame).
        baud_count = 18'd3; out_port = 8'hE5; eight = 1'b1; pen = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        for (int unsigned c = 0; c < 13; c++) step();
        check("pre_rst Tx bit3", Tx, 1'b0);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        check("midrst Tx", Tx, 1'b1);
        check("midrst TxRdy", TxRdy, 1'b1);
        idle("midrst", 3);
        send("post_midrst", 8'hE5, 1'b1, 1'b1, 1'b1, 3, -1, 8'h00);

        for (int unsigned n = 0; n < 12; n++) begin
            rd = 8'($urandom);
            send($sformatf("rand%0d", n), rd, 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 5), -1, 8'h00);
            if ($urandom_range(0, 1) == 1) idle("rand_gap", $urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
